// File: rtl/btn_move_conditioner.sv
// Push-button conditioner for the VGA pointer: synchronise and debounce five buttons,
// then turn the direction buttons into press/hold/auto-repeat move strobes plus a centre strobe.
module btn_move_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 40000000,
    parameter int REPEAT_CYCLES   = 4000000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_db,
    output logic       move_stb,
    output logic [3:0] move_dir,
    output logic       center_stb,
    output logic [1:0] dbg_state
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TM_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TM_W   = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] HOLD_LAST   = TM_W'(HOLD_CYCLES - 1);
    localparam logic [TM_W-1:0] REPEAT_LAST = TM_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [4:0]            r_sync1;
    logic [4:0]            r_sync2;
    logic [4:0]            r_db;
    logic [4:0][DB_W-1:0]  r_db_cnt;
    logic                  r_c_prev;
    logic                  r_center_stb;
    state_t                r_state;
    logic [TM_W-1:0]       r_timer;
    logic [3:0]            r_last_dir;
    logic                  r_move_stb;
    logic [3:0]            r_move_dir;

    logic [3:0]            w_dir;
    state_t                w_state_nxt;
    logic [TM_W-1:0]       w_timer_nxt;
    logic [3:0]            w_last_dir_nxt;
    logic                  w_stb_nxt;
    logic [3:0]            w_dir_nxt;

    // A debounce count only survives an unbroken run of mismatches.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_db     <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // {U,D,L,R}; opposing buttons cancel each other.
    assign w_dir = {r_db[1] & ~r_db[2], r_db[2] & ~r_db[1],
                    r_db[3] & ~r_db[4], r_db[4] & ~r_db[3]};

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer + 1'b1;
        w_last_dir_nxt = r_last_dir;
        w_stb_nxt      = 1'b0;
        w_dir_nxt      = 4'b0000;
        if (r_db[0]) begin
            w_state_nxt    = ST_IDLE;
            w_timer_nxt    = '0;
            w_last_dir_nxt = 4'b0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_timer_nxt = '0;
                    if (w_dir != 4'b0000) begin
                        w_stb_nxt      = 1'b1;
                        w_dir_nxt      = w_dir;
                        w_last_dir_nxt = w_dir;
                        w_state_nxt    = ST_HOLD;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (w_dir == 4'b0000) begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = '0;
                    end else if (w_dir != r_last_dir) begin
                        // A new direction restarts the hold delay from scratch.
                        w_stb_nxt      = 1'b1;
                        w_dir_nxt      = w_dir;
                        w_last_dir_nxt = w_dir;
                        w_timer_nxt    = '0;
                        w_state_nxt    = ST_HOLD;
                    end else if ((r_state == ST_HOLD   && r_timer == HOLD_LAST) ||
                                 (r_state == ST_REPEAT && r_timer == REPEAT_LAST)) begin
                        w_stb_nxt   = 1'b1;
                        w_dir_nxt   = w_dir;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_REPEAT;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_last_dir   <= 4'b0000;
            r_move_stb   <= 1'b0;
            r_move_dir   <= 4'b0000;
            r_c_prev     <= 1'b0;
            r_center_stb <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_last_dir   <= w_last_dir_nxt;
            r_move_stb   <= w_stb_nxt;
            r_move_dir   <= w_dir_nxt;
            r_c_prev     <= r_db[0];
            r_center_stb <= r_db[0] & ~r_c_prev;
        end
    end

    assign btn_db     = r_db;
    assign move_stb   = r_move_stb;
    assign move_dir   = r_move_dir;
    assign center_stb = r_center_stb;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_btn_move_conditioner.sv
// Directed bench for btn_move_conditioner with short debounce/hold/repeat settings.
module tb_btn_move_conditioner;

    logic       clk;
    logic       reset_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_db;
    logic       move_stb;
    logic [3:0] move_dir;
    logic       center_stb;
    logic [1:0] dbg_state;

    int n_vec;
    int n_err;
    int cyc;
    int base;
    int c_cnt;
    int b2b;
    logic prev_stb;
    int stb_cyc[$];
    logic [3:0] stb_dir[$];
    int exp_t3[7] = '{7, 27, 35, 43, 51, 59, 67};

    logic [10:0] out_all;
    assign out_all = {btn_db, move_stb, move_dir, center_stb};

    btn_move_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(20),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk_100MHz(clk),
        .reset_n(reset_n),
        .btn_raw(btn_raw),
        .btn_db(btn_db),
        .move_stb(move_stb),
        .move_dir(move_dir),
        .center_stb(center_stb),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and logging strobes.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (move_stb === 1'b1) begin
                stb_cyc.push_back(cyc);
                stb_dir.push_back(move_dir);
                if (prev_stb) b2b++;
            end
            prev_stb = (move_stb === 1'b1);
            if (center_stb === 1'b1) c_cnt++;
        end
    endtask

    task automatic clear_log();
        stb_cyc.delete();
        stb_dir.delete();
        base = cyc;
    endtask

    task automatic chk_stb(input string tag, input int idx, input int rel, input logic [3:0] d);
        int obs_t;
        logic [3:0] obs_d;
        obs_t = (idx < stb_cyc.size()) ? stb_cyc[idx] - base : -1;
        obs_d = (idx < stb_dir.size()) ? stb_dir[idx] : 4'hx;
        chk({tag, "_time"}, 16'(obs_t), 16'(rel));
        chk({tag, "_dir"}, {12'h0, obs_d}, {12'h0, d});
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; base = 0; c_cnt = 0; b2b = 0; prev_stb = 1'b0;
        reset_n = 1'b0;
        btn_raw = 5'b11111;

        // 1: reset holds everything at zero, then a clean btnU press
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("reset_outs", {5'h0, out_all}, 16'h0);
        end
        chk("reset_state", {14'h0, dbg_state}, 16'd0);
        reset_n = 1'b1;
        btn_raw = 5'b00010;
        clear_log();
        tick(5);
        chk("u_db_before", {11'h0, btn_db}, 16'h00);
        tick(1);
        chk("u_db_rise", {11'h0, btn_db}, 16'h02);
        chk("u_no_stb_yet", {15'h0, move_stb}, 16'h0);
        tick(1);
        chk("u_first_stb", {11'h0, move_stb, move_dir}, 16'h18);
        chk("u_state_hold", {14'h0, dbg_state}, 16'd1);
        tick(1);
        chk("u_stb_single", {11'h0, move_stb, move_dir}, 16'h00);
        btn_raw = 5'b00000;
        tick(10);
        chk("u_release_db", {11'h0, btn_db}, 16'h00);
        chk("u_release_idle", {14'h0, dbg_state}, 16'd0);
        chk("u_stb_count", 16'(stb_cyc.size()), 16'd1);

        // 2: bouncing btnU is rejected until it settles high
        clear_log();
        for (int i = 0; i < 10; i++) begin
            btn_raw[1] = ~btn_raw[1];
            tick(2);
        end
        chk("bounce_db_low", {11'h0, btn_db}, 16'h00);
        btn_raw[1] = 1'b1;
        tick(5);
        chk("bounce_db_wait", {11'h0, btn_db}, 16'h00);
        tick(1);
        chk("bounce_db_rise", {11'h0, btn_db}, 16'h02);
        tick(1);
        chk("bounce_stb", {11'h0, move_stb, move_dir}, 16'h18);
        btn_raw = 5'b00000;
        tick(12);
        chk("bounce_stb_count", 16'(stb_cyc.size()), 16'd1);
        chk("bounce_idle", {14'h0, dbg_state}, 16'd0);

        // 3: btnR hold -> press strobe, hold delay, then repeat train
        btn_raw = 5'b10000;
        clear_log();
        tick(68);
        btn_raw = 5'b00000;
        tick(20);
        chk("r_stb_count", 16'(stb_cyc.size()), 16'd7);
        for (int i = 0; i < 7; i++) chk_stb("r_train", i, exp_t3[i], 4'b0001);
        chk("r_idle", {14'h0, dbg_state}, 16'd0);

        // 4: diagonal U+L, then cancelling U+D
        btn_raw = 5'b01010;
        tick(7);
        chk("ul_stb", {11'h0, move_stb, move_dir}, 16'h1A);
        chk("ul_db", {11'h0, btn_db}, 16'h0A);
        btn_raw = 5'b00000;
        tick(10);
        btn_raw = 5'b00110;
        tick(6);
        chk("ud_db", {11'h0, btn_db}, 16'h06);
        clear_log();
        tick(25);
        chk("ud_no_stb", 16'(stb_cyc.size()), 16'd0);
        chk("ud_idle", {14'h0, dbg_state}, 16'd0);
        btn_raw = 5'b00000;
        tick(8);
        chk("ud_release_db", {11'h0, btn_db}, 16'h00);

        // 5: centre press during repeat, then release with btnR still held
        btn_raw = 5'b10000;
        clear_log();
        tick(27);
        chk("c_pre_count", 16'(stb_cyc.size()), 16'd2);
        chk_stb("c_pre_second", 1, 27, 4'b0001);
        chk("c_pre_repeat", {14'h0, dbg_state}, 16'd2);
        btn_raw = 5'b10001;
        clear_log();
        c_cnt = 0;
        tick(6);
        chk("c_db_rise", {11'h0, btn_db}, 16'h11);
        chk("c_stb_not_yet", {15'h0, center_stb}, 16'h0);
        tick(1);
        chk("c_stb", {15'h0, center_stb}, 16'h1);
        tick(15);
        chk("c_stb_count", 16'(c_cnt), 16'd1);
        chk("c_move_suppressed", 16'(stb_cyc.size()), 16'd0);
        chk("c_idle", {14'h0, dbg_state}, 16'd0);
        btn_raw = 5'b10000;
        clear_log();
        tick(30);
        chk("c_rel_count", 16'(stb_cyc.size()), 16'd2);
        chk_stb("c_rel_first", 0, 7, 4'b0001);
        chk_stb("c_rel_second", 1, 27, 4'b0001);
        chk("c_rel_no_center", 16'(c_cnt), 16'd1);
        chk("c_rel_repeat", {14'h0, dbg_state}, 16'd2);

        // 6: one-cycle reset during repeat aborts and forces a re-debounce
        reset_n = 1'b0;
        tick(1);
        chk("rst_mid_outs", {5'h0, out_all}, 16'h0);
        chk("rst_mid_state", {14'h0, dbg_state}, 16'd0);
        reset_n = 1'b1;
        clear_log();
        tick(5);
        chk("rst_db_wait", {11'h0, btn_db}, 16'h00);
        tick(1);
        chk("rst_db_rise", {11'h0, btn_db}, 16'h10);
        chk("rst_no_stb_yet", {15'h0, move_stb}, 16'h0);
        tick(1);
        chk("rst_first_stb", {11'h0, move_stb, move_dir}, 16'h11);
        tick(10);
        chk("rst_stb_count", 16'(stb_cyc.size()), 16'd1);

        btn_raw = 5'b00000;
        tick(10);
        chk("no_back_to_back", 16'(b2b), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
